// File: rtl/drum_div_seq_if.sv
// drum_div_seq_if: operand/result handshake bundle for the DRUM approximate divider.
//   in_valid/in_ready  : operand pair handshake (a = dividend, b = divisor)
//   out_valid/out_ready: result handshake (r = approximate quotient, dz = divide-by-zero)
// master drives operands and accepts results; slave is the divider.
interface drum_div_seq_if #(
  parameter int N = 16,
  parameter int M = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] r;
  logic         dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, r, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, r, dz
  );
endinterface

// File: rtl/drum_div_seq.sv
// drum_div_seq: sequential approximate signed divider (DRUM-style K-bit mantissas).
// Operands are reduced to unbiased K-bit mantissas (leading-one detect, truncate, LSB forced
// to 1), divided by a restoring shift-subtract loop (one quotient bit per cycle) and rescaled
// by the exponent difference.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : drum_div_seq_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/r/dz)
// Optional feature: define DRUM_DIV_ROUND_EN to round half up on right rescaling shifts
// (default: plain truncation). Latency is the same in both builds.
module drum_div_seq #(
  parameter int K = 8,
  parameter int N = 16,
  parameter int M = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  drum_div_seq_if.slave  io_bus
);

  localparam int SW = $clog2(N + M) + 2;  // signed exponent / shift width
  localparam int CW = $clog2(2 * K);
  localparam int WW = 2 * K + N;          // room for left-shifting Q before truncation

  typedef enum logic [2:0] {StIdle, StNorm, StDiv, StShift, StDone} state_e;

  state_e          r_state;
  logic            r_sign;
  logic            r_dz;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [N-1:0]    r_abs_a;
  logic [M-1:0]    r_abs_b;
  logic [N-1:0]    r_r;
  logic [K-1:0]    r_mb;
  logic [SW-1:0]   r_ea;
  logic [SW-1:0]   r_eb;
  logic [2*K-1:0]  r_num;
  logic [2*K-1:0]  r_q;
  logic [K:0]      r_rem;
  logic [CW-1:0]   r_cnt;

  // Leading-one detect and mantissa reduction
  int              w_ka;
  int              w_kb;
  logic [K-1:0]    w_ma;
  logic [K-1:0]    w_mb;
  logic [SW-1:0]   w_ea;
  logic [SW-1:0]   w_eb;

  always_comb begin
    w_ka = 0;
    for (int i = 0; i < N; i++) begin
      if (r_abs_a[i]) w_ka = i;
    end
    w_ma = r_abs_a[K-1:0];
    w_ea = '0;
    if (w_ka > K - 1) begin
      // Keep the K-1 bits below and including the leading one, then force LSB to 1
      w_ma = {(K-1)'(r_abs_a >> (w_ka - (K - 2))), 1'b1};
      w_ea = SW'(w_ka - (K - 1));
    end
  end

  always_comb begin
    w_kb = 0;
    for (int i = 0; i < M; i++) begin
      if (r_abs_b[i]) w_kb = i;
    end
    w_mb = r_abs_b[K-1:0];
    w_eb = '0;
    if (w_kb > K - 1) begin
      w_mb = {(K-1)'(r_abs_b >> (w_kb - (K - 2))), 1'b1};
      w_eb = SW'(w_kb - (K - 1));
    end
  end

  // Restoring division step
  logic [K+1:0] w_rem_sh;
  logic         w_qbit;

  always_comb begin
    w_rem_sh = {r_rem, r_num[2*K-1]};
    w_qbit   = (w_rem_sh >= (K+2)'(r_mb));
  end

  // Rescale by exponent difference and apply sign / divide-by-zero result
  logic signed [SW-1:0] w_s;
  logic [SW-1:0]        w_nsh;
  logic [WW-1:0]        w_q_wide;
  logic [N-1:0]         w_mag;
  logic [N-1:0]         w_r;

  always_comb begin
    w_s      = r_ea - r_eb - SW'(K);
    w_nsh    = -w_s;
    w_q_wide = WW'(r_q);
    if (w_s[SW-1]) begin
      w_mag = N'(w_q_wide >> w_nsh);
`ifdef DRUM_DIV_ROUND_EN
      // Round half up: add the last bit shifted out
      w_mag = w_mag + N'(1'(w_q_wide >> (w_nsh - SW'(1))));
`endif
    end else begin
      w_mag = N'(w_q_wide << w_s);
    end
    if (r_dz) begin
      w_r = r_sign ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      w_r = r_sign ? ~w_mag : w_mag;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_sign      <= 1'b0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_abs_a     <= '0;
      r_abs_b     <= '0;
      r_r         <= '0;
      r_mb        <= '0;
      r_ea        <= '0;
      r_eb        <= '0;
      r_num       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.in_valid) begin
            r_sign     <= io_bus.a[N-1] ^ io_bus.b[M-1];
            // Ones'-complement magnitude, matching the DRUM multiplier
            r_abs_a    <= io_bus.a[N-1] ? ~io_bus.a : io_bus.a;
            r_abs_b    <= io_bus.b[M-1] ? ~io_bus.b : io_bus.b;
            r_dz       <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= StNorm;
          end
        end
        StNorm: begin
          r_mb <= w_mb;
          r_ea <= w_ea;
          r_eb <= w_eb;
          if (r_abs_b == '0) begin
            r_dz    <= 1'b1;
            r_state <= StShift;
          end else begin
            r_num   <= {w_ma, {K{1'b0}}};
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_state <= StDiv;
          end
        end
        StDiv: begin
          r_rem <= w_qbit ? (K+1)'(w_rem_sh - (K+2)'(r_mb)) : w_rem_sh[K:0];
          r_num <= {r_num[2*K-2:0], 1'b0};
          r_q   <= {r_q[2*K-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(2 * K - 1)) r_state <= StShift;
        end
        StShift: begin
          r_r         <= w_r;
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
        StDone: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.r         = r_r;
  assign io_bus.dz        = r_dz;

endmodule

// File: tb/tb_drum_div_seq.sv
// tb_drum_div_seq: scoreboard bench for drum_div_seq (K=8, N=M=16).
// Expected results are queued when operands are driven and compared when the result
// handshake completes. DRUM_DIV_ROUND_EN selects the rounding build's expectations.
module tb_drum_div_seq;

  localparam int K = 8;
  localparam int N = 16;
  localparam int M = 16;

`ifdef DRUM_DIV_ROUND_EN
  localparam logic [15:0] TruncCaseExp = 16'd100;
`else
  localparam logic [15:0] TruncCaseExp = 16'd99;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drum_div_seq_if #(.N(N), .M(M)) bus ();

  drum_div_seq #(.K(K), .N(N), .M(M)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_out  = 0;
  int          n_push = 0;
  logic [16:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: DRUM mantissa reduction, integer division, exponent rescale
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
    logic        sign;
    logic [15:0] ua, ub, mag;
    int          ka, kb, ma, mb, ea, eb, q, s;
    sign = a[15] ^ b[15];
    ua = a[15] ? ~a : a;
    ub = b[15] ? ~b : b;
    if (ub == 16'd0) return {1'b1, sign ? 16'h8000 : 16'h7fff};
    ka = 0;
    kb = 0;
    for (int i = 0; i < 16; i++) begin
      if (ua[i]) ka = i;
      if (ub[i]) kb = i;
    end
    if (ka > 7) begin ma = (int'(ua) >> (ka - 7)) | 1; ea = ka - 7; end
    else begin ma = int'(ua); ea = 0; end
    if (kb > 7) begin mb = (int'(ub) >> (kb - 7)) | 1; eb = kb - 7; end
    else begin mb = int'(ub); eb = 0; end
    q = (ma * 256) / mb;
    s = ea - eb - 8;
    if (s >= 0) mag = 16'(q << s);
    else begin
      mag = 16'(q >> (-s));
`ifdef DRUM_DIV_ROUND_EN
      mag = mag + 16'((q >> (-s - 1)) & 1);
`endif
    end
    return {1'b0, sign ? ~mag : mag};
  endfunction

  // Result monitor: out_ready is raised for exactly one falling edge per handshake
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("result_r", 32'(bus.r), 32'(e[15:0]));
        check_eq("result_dz", 32'(bus.dz), 32'(e[16]));
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                       input logic edz, input int lat, input int hold);
    int          n;
    logic [15:0] r_hold;
    sb.push_back({edz, er});
    n_push++;
    check_eq("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq("in_ready_drop", 32'(bus.in_ready), 32'd0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
      // Stray operand while busy must be ignored
      if (n == 3) begin bus.in_valid = 1'b1; bus.a = 16'h1234; bus.b = 16'h0003; end
      if (n == 4) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    check_eq("latency", 32'(n), 32'(lat));
    r_hold = bus.r;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      @(posedge clk); #1;
      check_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stall_r", 32'(bus.r), 32'(r_hold));
      check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("in_ready_back", 32'(bus.in_ready), 32'd1);
    check_eq("out_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_model_op(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [16:0] e;
    e = model(a, b);
    do_op(a, b, e[15:0], e[16], e[16] ? 2 : 18, hold);
  endtask

  initial begin
    logic [15:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_r", 32'(bus.r), 32'd0);
    check_eq("rst_dz", 32'(bus.dz), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(16'd100, 16'd7, 16'd14, 1'b0, 18, 0);
    do_op(16'd30000, 16'd300, TruncCaseExp, 1'b0, 18, 0);
    do_op(16'hFF9C, 16'd7, 16'hFFF1, 1'b0, 18, 0);
    do_op(16'd5, 16'd0, 16'h7FFF, 1'b1, 2, 0);
    do_op(16'hFFFB, 16'hFFFF, 16'h7FFF, 1'b1, 2, 0);
    do_op(16'hFFFB, 16'd0, 16'h8000, 1'b1, 2, 0);
    do_model_op(16'h7FFF, 16'd1, 0);
    do_model_op(16'h8000, 16'd1, 0);
    do_model_op(16'd1, 16'h7FFF, 0);
    // Stalled consumer
    do_model_op(16'd1000, 16'd3, 10);

    // Reset in the middle of DIV aborts without a result
    bus.a        = 16'd100;
    bus.b        = 16'd7;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("busy_before_rst", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_r", 32'(bus.r), 32'd0);
    check_eq("abort_dz", 32'(bus.dz), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check_eq("no_result_after_abort", 32'(bus.out_valid), 32'd0);
    do_op(16'd100, 16'd7, 16'd14, 1'b0, 18, 0);

    // Random operands
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(0, 4000));
      if ($urandom_range(0, 1) == 1) rb = ~rb;
      if (i % 5 == 4) rb = 16'($urandom);
      do_model_op(ra, rb, (i % 7 == 3) ? 3 : 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("result_count", 32'(n_out), 32'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
